// File: rtl/pool_window_feeder.sv
// Max-pool column source: buffers MAXPOOL_SIZE-1 rows and emits one
// vertical pixel column per accepted pixel once the window is full.
`ifndef FEATURE_WIDTH
`define FEATURE_WIDTH 8
`endif
`ifndef MAXPOOL_SIZE
`define MAXPOOL_SIZE 5
`endif

module pool_window_feeder #(
    parameter int FEATURE_WIDTH = `FEATURE_WIDTH,
    parameter int MAXPOOL_SIZE  = `MAXPOOL_SIZE,
    parameter int MAX_IMG_WIDTH = 64,
    parameter int DIM_WIDTH     = 8
) (
    input  logic                                  DSP_clk,
    input  logic                                  rst_n,
    input  logic                                  start,
    input  logic [DIM_WIDTH-1:0]                  img_width,
    input  logic [DIM_WIDTH-1:0]                  img_height,
    input  logic [FEATURE_WIDTH-1:0]              pixel_in,
    input  logic                                  pixel_valid,
    output logic                                  pixel_ready,
    output logic [FEATURE_WIDTH*MAXPOOL_SIZE-1:0] feature,
    output logic                                  pulse,
    output logic                                  row_first,
    output logic                                  frame_done
);

    localparam int LB_ROWS = MAXPOOL_SIZE - 1;
    localparam int CW      = $clog2(MAX_IMG_WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_STREAM,
        S_DONE
    } state_e;

    state_e state_q, state_d;

    logic [DIM_WIDTH-1:0] wm1_q, wm1_d;
    logic [DIM_WIDTH-1:0] hm1_q, hm1_d;
    logic [DIM_WIDTH-1:0] col_q, col_d;
    logic [DIM_WIDTH-1:0] row_q, row_d;

    logic [FEATURE_WIDTH-1:0] lb_q [LB_ROWS][MAX_IMG_WIDTH];
    logic [FEATURE_WIDTH-1:0] lb_d [LB_ROWS][MAX_IMG_WIDTH];

    logic [FEATURE_WIDTH*MAXPOOL_SIZE-1:0] feature_q, feature_d;
    logic pulse_q, pulse_d;
    logic row_first_q, row_first_d;

    logic          accept;
    logic          dims_ok;
    logic          last_col;
    logic          last_row;
    logic          fill_row;
    logic [CW-1:0] cidx;

    assign pixel_ready = (state_q == S_FILL) || (state_q == S_STREAM);
    assign frame_done  = (state_q == S_DONE);
    assign accept      = pixel_valid && pixel_ready;
    assign cidx        = col_q[CW-1:0];
    assign last_col    = (col_q == wm1_q);
    assign last_row    = (row_q == hm1_q);
    assign fill_row    = (row_q == DIM_WIDTH'(MAXPOOL_SIZE - 2));

    assign dims_ok = (32'(img_width) >= MAXPOOL_SIZE)
                  && (32'(img_width) <= MAX_IMG_WIDTH)
                  && (32'(img_height) >= MAXPOOL_SIZE);

    assign feature   = feature_q;
    assign pulse     = pulse_q;
    assign row_first = row_first_q;

    always_comb begin
        state_d     = state_q;
        wm1_d       = wm1_q;
        hm1_d       = hm1_q;
        col_d       = col_q;
        row_d       = row_q;
        lb_d        = lb_q;
        feature_d   = feature_q;
        pulse_d     = 1'b0;
        row_first_d = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    col_d = '0;
                    row_d = '0;
                    if (dims_ok) begin
                        state_d = S_FILL;
                        wm1_d   = img_width - DIM_WIDTH'(1);
                        hm1_d   = img_height - DIM_WIDTH'(1);
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_FILL: begin
                if (accept && last_col && fill_row) state_d = S_STREAM;
            end
            S_STREAM: begin
                if (accept && last_col && last_row) state_d = S_DONE;
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (accept) begin
            col_d = last_col ? '0 : col_q + DIM_WIDTH'(1);
            if (last_col) row_d = row_q + DIM_WIDTH'(1);
            // Shift the column up one row; the newest pixel enters at the bottom
            for (int k = 0; k < LB_ROWS - 1; k++) begin
                lb_d[k][cidx] = lb_q[k+1][cidx];
            end
            lb_d[LB_ROWS-1][cidx] = pixel_in;
            if (state_q == S_STREAM) begin
                pulse_d     = 1'b1;
                row_first_d = (col_q == '0);
                for (int i = 0; i < LB_ROWS; i++) begin
                    feature_d[FEATURE_WIDTH*i +: FEATURE_WIDTH] = lb_q[i][cidx];
                end
                feature_d[FEATURE_WIDTH*LB_ROWS +: FEATURE_WIDTH] = pixel_in;
            end
        end
    end

    always_ff @(posedge DSP_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            wm1_q       <= '0;
            hm1_q       <= '0;
            col_q       <= '0;
            row_q       <= '0;
            lb_q        <= '{default: '0};
            feature_q   <= '0;
            pulse_q     <= 1'b0;
            row_first_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wm1_q       <= wm1_d;
            hm1_q       <= hm1_d;
            col_q       <= col_d;
            row_q       <= row_d;
            lb_q        <= lb_d;
            feature_q   <= feature_d;
            pulse_q     <= pulse_d;
            row_first_q <= row_first_d;
        end
    end

endmodule

// File: tb/tb_pool_window_feeder.sv
// Directed and randomized frames for pool_window_feeder, checked against a
// frame-array reference of the expected column stream.
module tb_pool_window_feeder;

    localparam int FW = 8;
    localparam int M  = 5;

    logic              DSP_clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [7:0]        img_width;
    logic [7:0]        img_height;
    logic [FW-1:0]     pixel_in;
    logic              pixel_valid;
    logic              pixel_ready;
    logic [FW*M-1:0]   feature;
    logic              pulse;
    logic              row_first;
    logic              frame_done;

    logic signed [FW-1:0] pix [8][64];
    logic [FW*M-1:0]      exp_feat;
    int n_assert = 0;
    int n_fail   = 0;

    pool_window_feeder #(
        .FEATURE_WIDTH(FW),
        .MAXPOOL_SIZE(M),
        .MAX_IMG_WIDTH(64),
        .DIM_WIDTH(8)
    ) dut (
        .DSP_clk(DSP_clk),
        .rst_n(rst_n),
        .start(start),
        .img_width(img_width),
        .img_height(img_height),
        .pixel_in(pixel_in),
        .pixel_valid(pixel_valid),
        .pixel_ready(pixel_ready),
        .feature(feature),
        .pulse(pulse),
        .row_first(row_first),
        .frame_done(frame_done)
    );

    always #5 DSP_clk = ~DSP_clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_ready"}, pixel_ready, 0);
        chk({tag, "_pulse"}, pulse, 0);
        chk({tag, "_row_first"}, row_first, 0);
        chk({tag, "_done"}, frame_done, 0);
        chk({tag, "_feature"}, feature, 0);
    endtask

    // kind 0: row*16+col, 1: -(col+1), other: random
    task automatic fill(input int kind);
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 64; c++) begin
                case (kind)
                    0:       pix[r][c] = FW'(r * 16 + c);
                    1:       pix[r][c] = FW'(-(c + 1));
                    default: pix[r][c] = FW'($urandom);
                endcase
            end
        end
    endtask

    // vmode 0: valid held high, 1: every other cycle, other: random
    task automatic run_frame(input int w, input int h, input int vmode,
                             input int max_acc);
        int n = 0;
        int cyc = 0;
        int pc = 0;
        int rfc = 0;
        int r;
        int c;
        logic acc;
        logic ep;
        logic erf;
        logic efd;
        img_width  = w[7:0];
        img_height = h[7:0];
        start      = 1'b1;
        @(posedge DSP_clk); #1;
        start = 1'b0;
        chk("ready_rise", pixel_ready, 1);
        while (n < max_acc && cyc < 4000) begin
            case (vmode)
                0:       pixel_valid = 1'b1;
                1:       pixel_valid = (cyc % 2 == 0);
                default: pixel_valid = 1'($urandom_range(0, 1));
            endcase
            r = n / w;
            c = n % w;
            pixel_in = pixel_valid ? pix[r][c] : FW'($urandom);
            @(negedge DSP_clk);
            acc = pixel_valid && pixel_ready;
            @(posedge DSP_clk); #1;
            ep  = 1'b0;
            erf = 1'b0;
            efd = 1'b0;
            if (acc) begin
                if (r >= M - 1) begin
                    ep  = 1'b1;
                    erf = (c == 0);
                    for (int i = 0; i < M; i++)
                        exp_feat[FW*i +: FW] = pix[r-M+1+i][c];
                end
                n++;
                efd = (n == w * h);
            end
            pc  += int'(pulse);
            rfc += int'(pulse && row_first);
            chk("pulse", pulse, ep);
            chk("row_first", row_first, erf);
            chk("feature", feature, exp_feat);
            chk("frame_done", frame_done, efd);
            chk("ready", pixel_ready, n < w * h);
            cyc++;
        end
        pixel_valid = 1'b0;
        chk("accepted", n, max_acc);
        if (max_acc == w * h) begin
            chk("pulse_count", pc, (h - M + 1) * w);
            chk("row_first_count", rfc, h - M + 1);
            start = 1'b1;
            @(posedge DSP_clk); #1;
            start = 1'b0;
            chk("done_one_cycle", frame_done, 0);
            chk("ready_after_done", pixel_ready, 0);
            chk("pulse_after_done", pulse, 0);
        end
    endtask

    task automatic invalid_frame(input int w, input int h);
        img_width  = w[7:0];
        img_height = h[7:0];
        start      = 1'b1;
        @(posedge DSP_clk); #1;
        start       = 1'b0;
        pixel_valid = 1'b1;
        pixel_in    = FW'($urandom);
        chk("inv_done", frame_done, 1);
        chk("inv_ready", pixel_ready, 0);
        chk("inv_pulse", pulse, 0);
        repeat (3) begin
            @(posedge DSP_clk); #1;
            chk("inv_ready_hold", pixel_ready, 0);
            chk("inv_pulse_hold", pulse, 0);
            chk("inv_done_once", frame_done, 0);
        end
        pixel_valid = 1'b0;
    endtask

    initial begin
        int w;
        int h;
        rst_n       = 1'b0;
        start       = 1'b0;
        img_width   = '0;
        img_height  = '0;
        pixel_in    = '0;
        pixel_valid = 1'b0;
        exp_feat    = '0;
        #12;
        chk_idle_outputs("reset");
        @(negedge DSP_clk);
        rst_n = 1'b1;
        @(posedge DSP_clk); #1;

        fill(0);
        run_frame(6, 5, 0, 30);
        run_frame(6, 7, 0, 42);
        run_frame(6, 5, 1, 30);

        invalid_frame(4, 5);
        invalid_frame(65, 5);

        run_frame(6, 5, 0, 26);
        #2;
        rst_n = 1'b0;
        #1;
        chk_idle_outputs("async_reset");
        exp_feat = '0;
        @(negedge DSP_clk);
        rst_n = 1'b1;
        @(posedge DSP_clk); #1;
        chk("post_reset_ready", pixel_ready, 0);
        run_frame(6, 5, 0, 30);

        fill(1);
        run_frame(64, 5, 0, 320);

        for (int k = 0; k < 3; k++) begin
            w = int'($urandom_range(5, 64));
            h = int'($urandom_range(5, 8));
            fill(2);
            run_frame(w, h, 2, w * h);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
